// File: rtl/ui_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : ui_request_gen
// Description : Push-button front end for the combined-bus master. Debounces
//               an active-low button, captures address/data/rw fields from the
//               switch bank in config mode and, in run mode, issues one
//               valid/ready request per press.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_request_gen #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  button1_raw,
  input  logic                  mode_switch,
  input  logic [11:0]           switch_array,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_rw,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  cfg_field,
  output logic                  press_pulse
);

  // Counter wide enough to hold DEBOUNCE_CYCLES; it clears at the threshold
  // so it can never wrap.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] db_cnt;

  logic                  cfg_rw;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [DATA_WIDTH-1:0] cfg_wdata;

  logic accept;
  logic load_req;

  // Two-flop synchronizer; idle level of the button is high.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button1_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a level change only after it persists long enough.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 != stable) begin
      if (db_cnt == CNT_LAST) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // One-cycle pulse on each falling edge of the debounced level (press only).
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stable_d    <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      stable_d    <= stable;
      press_pulse <= stable_d & ~stable;
    end
  end

  assign accept = press_pulse & enable;

  // Config capture alternates address and data/rw; allowed in any FSM state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cfg_field <= 1'b0;
      cfg_addr  <= '0;
      cfg_wdata <= '0;
      cfg_rw    <= 1'b0;
    end else if (accept && !mode_switch) begin
      cfg_field <= ~cfg_field;
      if (!cfg_field) begin
        cfg_addr <= switch_array[ADDR_WIDTH-1:0];
      end else begin
        cfg_wdata <= switch_array[DATA_WIDTH-1:0];
        cfg_rw    <= switch_array[8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: run-mode presses are only taken from IDLE.
  always_comb begin
    next_state = state;
    load_req   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && mode_switch) begin
          next_state = REQ;
          load_req   = 1'b1;
        end
      end
      REQ: begin
        if (req_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are snapshotted at issue and held until acceptance.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (load_req) begin
      req_rw    <= cfg_rw;
      req_addr  <= cfg_addr;
      req_wdata <= cfg_wdata;
    end
  end

  assign req_valid = (state == REQ);

endmodule
`default_nettype wire

// File: tb/tb_ui_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ui_request_gen
// Description : Directed self-checking bench for ui_request_gen with a
//               scoreboard of expected bus requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ui_request_gen;

  localparam int DB = 4;

  logic        clock;
  logic        rst;
  logic        enable;
  logic        button1_raw;
  logic        mode_switch;
  logic [11:0] switch_array;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        cfg_field;
  logic        press_pulse;

  int checks   = 0;
  int failures = 0;
  int pulse_count = 0;

  // expected request packed as {rw, addr, wdata}
  logic [20:0] exp_q[$];

  ui_request_gen #(
    .DEBOUNCE_CYCLES(DB),
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8)
  ) dut (
    .clock(clock),
    .rst(rst),
    .enable(enable),
    .button1_raw(button1_raw),
    .mode_switch(mode_switch),
    .switch_array(switch_array),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .cfg_field(cfg_field),
    .press_pulse(press_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input int low_cycles, input int rel_cycles);
    button1_raw = 1'b0;
    repeat (low_cycles) tick();
    button1_raw = 1'b1;
    repeat (rel_cycles) tick();
  endtask

  // Scoreboard: a handshake completes at the next rising edge.
  always @(negedge clock) begin
    if (!rst) begin
      if (press_pulse) pulse_count++;
      if (req_valid && req_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_request", {11'd0, req_rw, req_addr, req_wdata}, 32'hFFFF_FFFF);
        end else begin
          check("request_fields", {11'd0, req_rw, req_addr, req_wdata}, {11'd0, exp_q.pop_front()});
        end
      end
    end
  end

  int p0;

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    button1_raw  = 1'b1;
    mode_switch  = 1'b1;
    switch_array = 12'h000;
    req_ready    = 1'b1;
    repeat (3) tick();
    check("reset_req_valid", {31'd0, req_valid}, 32'd0);
    check("reset_req_addr", {20'd0, req_addr}, 32'd0);
    check("reset_cfg_field", {31'd0, cfg_field}, 32'd0);
    check("reset_press_pulse", {31'd0, press_pulse}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Debounce latency: pulse after E7, valid for exactly one cycle after E8.
    exp_q.push_back({1'b0, 12'h000, 8'h00});
    p0 = pulse_count;
    button1_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("latency_pulse_E%0d", k), {31'd0, press_pulse}, {31'd0, (k == DB + 3)});
      check($sformatf("latency_valid_E%0d", k), {31'd0, req_valid}, {31'd0, (k == DB + 4)});
    end
    button1_raw = 1'b1;
    repeat (10) tick();
    check("hold_single_pulse", pulse_count - p0, 32'd1);
    check("hold_queue_drained", exp_q.size(), 32'd0);

    // Short bounce: no pulse.
    p0 = pulse_count;
    press(3, 15);
    check("bounce_no_pulse", pulse_count - p0, 32'd0);

    // Config capture, then write request.
    mode_switch  = 1'b0;
    switch_array = 12'h0A5;
    press(8, 10);
    check("cfg_field_after_addr", {31'd0, cfg_field}, 32'd1);
    switch_array = 12'h03C;
    press(8, 10);
    check("cfg_field_after_data", {31'd0, cfg_field}, 32'd0);
    mode_switch = 1'b1;
    exp_q.push_back({1'b0, 12'h0A5, 8'h3C});
    press(8, 10);
    check("write_queue_drained", exp_q.size(), 32'd0);
    check("write_cfg_field", {31'd0, cfg_field}, 32'd0);

    // Handshake stall: fields held, extra press dropped.
    req_ready = 1'b0;
    exp_q.push_back({1'b0, 12'h0A5, 8'h3C});
    press(8, 4);
    check("stall_valid_raised", {31'd0, req_valid}, 32'd1);
    p0 = pulse_count;
    switch_array = 12'hFFF;
    press(8, 10);
    check("stall_second_pulse", pulse_count - p0, 32'd1);
    check("stall_valid_held", {31'd0, req_valid}, 32'd1);
    check("stall_fields_held", {11'd0, req_rw, req_addr, req_wdata}, {11'd0, 1'b0, 12'h0A5, 8'h3C});
    req_ready = 1'b1;
    tick();
    check("stall_valid_cleared", {31'd0, req_valid}, 32'd0);
    repeat (20) tick();
    check("stall_no_second_req", {31'd0, req_valid}, 32'd0);
    check("stall_queue_drained", exp_q.size(), 32'd0);

    // Enable gating: pulses still fire, nothing captured or issued.
    enable       = 1'b0;
    mode_switch  = 1'b0;
    switch_array = 12'h777;
    p0 = pulse_count;
    press(8, 10);
    check("gated_cfg_field", {31'd0, cfg_field}, 32'd0);
    mode_switch = 1'b1;
    press(8, 10);
    check("gated_pulses", pulse_count - p0, 32'd2);
    check("gated_no_request", {31'd0, req_valid}, 32'd0);
    enable = 1'b1;
    exp_q.push_back({1'b0, 12'h0A5, 8'h3C});
    press(8, 10);
    check("enabled_queue_drained", exp_q.size(), 32'd0);

    // Read request.
    mode_switch  = 1'b0;
    switch_array = 12'h123;
    press(8, 10);
    switch_array = 12'h1FF;
    press(8, 10);
    mode_switch = 1'b1;
    exp_q.push_back({1'b1, 12'h123, 8'hFF});
    press(8, 10);
    check("read_queue_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-request.
    req_ready = 1'b0;
    press(8, 4);
    check("pre_reset_valid", {31'd0, req_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_valid", {31'd0, req_valid}, 32'd0);
    check("async_reset_fields", {11'd0, req_rw, req_addr, req_wdata}, 32'd0);
    check("async_reset_cfg_field", {31'd0, cfg_field}, 32'd0);
    check("async_reset_pulse", {31'd0, press_pulse}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    req_ready = 1'b1;
    repeat (2) tick();
    exp_q.push_back({1'b0, 12'h000, 8'h00});
    press(8, 10);
    check("post_reset_queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ui_request_gen.md
# ui_request_gen

Front-end stage feeding the combined-bus top level. It debounces the active-low push-button, captures transaction fields from `switch_array` in configuration mode, and in run mode issues one bus request per press to the downstream master interface over a valid/ready handshake. It turns raw board inputs (`button1_raw`, `mode_switch`, `switch_array`, `enable`) into clean, single-issue, cycle-stable requests for the bus master.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 10: consecutive stable cycles required to accept a button level change; legal range 2..65535.
- `ADDR_WIDTH`, default 12: request address width.
- `DATA_WIDTH`, default 8: request write-data width.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = button presses are acted on; 0 = presses are discarded.
- `button1_raw`  in  1  raw push-button, active-low (0 = pressed), asynchronous to `clock`.
- `mode_switch`  in  1  1 = run mode (press issues a request); 0 = config mode (press captures a field).
- `switch_array`  in  12  field value source in config mode.
- `req_valid`  out  1  request pending toward the master.
- `req_ready`  in  1  master accepts the request when it is high together with `req_valid`.
- `req_rw`  out  1  0 = write, 1 = read.
- `req_addr`  out  ADDR_WIDTH  request address.
- `req_wdata`  out  DATA_WIDTH  request write data.
- `cfg_field`  out  1  next config field to capture: 0 = address, 1 = data/rw.
- `press_pulse`  out  1  one-cycle debounced press indication, exported for the display and for debug.

## Operation

- Synchronizer: 2-flop chain on `button1_raw`; both flops reset to 1.
- Debouncer: register `stable` resets to 1. A counter increments on each edge where the synchronized level differs from `stable` and clears on any edge where they match. On the edge where the count would reach `DEBOUNCE_CYCLES`, `stable` takes the synchronized level and the counter clears.
- `press_pulse` is registered and is high for exactly one cycle after each 1->0 transition of `stable`. Releases (0->1) produce no pulse.
- Presses are acted on only when `press_pulse`=1 and `enable`=1. The debouncer runs regardless of `enable`.
- Config mode (`mode_switch`=0):
  - Press with `cfg_field`=0: `cfg_addr` <= `switch_array[ADDR_WIDTH-1:0]`.
  - Press with `cfg_field`=1: `cfg_wdata` <= `switch_array[DATA_WIDTH-1:0]` and `cfg_rw` <= `switch_array[8]`.
  - Each press toggles `cfg_field`, so capture alternates address, data, address, and so on.
  - Config captures are accepted in any FSM state. They do not alter an in-flight request.
- FSM states:
  - IDLE -> REQ on an accepted press with `mode_switch`=1. On that edge, `req_addr`, `req_wdata` and `req_rw` are loaded from `cfg_addr`, `cfg_wdata` and `cfg_rw`, and `req_valid` is set to 1.
  - REQ -> IDLE on the edge where `req_valid`=1 and `req_ready`=1; `req_valid` clears on that edge.
- In REQ, run-mode presses are dropped, not queued. `req_*` outputs are held constant until acceptance. Changes to `mode_switch` or `enable` do not cancel the request.
- Reset (asynchronous, any time, including mid-request):
  - `req_valid`=0, `req_rw`=0, `req_addr`=0, `req_wdata`=0, `cfg_field`=0, `press_pulse`=0.
  - `cfg_addr`, `cfg_wdata`, `cfg_rw` = 0; FSM = IDLE; counter = 0.
  - A pending request is lost, and the master must see `req_valid` fall.

## Timing

- Edges are counted from E1, the first rising edge at which `button1_raw`=0 is sampled:
  - synchronized level = 0 after E2;
  - `stable` = 0 after E(2+DEBOUNCE_CYCLES);
  - `press_pulse` high for the cycle after E(3+DEBOUNCE_CYCLES);
  - `req_valid` high after E(4+DEBOUNCE_CYCLES).
- Total press-to-request latency is DEBOUNCE_CYCLES+4 edges.
- A glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output produces no pulse.
- If `req_ready` is already 1 when `req_valid` rises, `req_valid` is high for exactly one cycle.
- A press pulse in the same cycle as the acceptance handshake is dropped, because the FSM is still in REQ. Minimum spacing between issued requests is one full debounce of the next press.
- Counter width is ceil(log2(DEBOUNCE_CYCLES+1)). The counter never wraps, because it clears at the threshold.

## Test plan

- Debounce, DEBOUNCE_CYCLES=4, `req_ready`=1: hold `button1_raw` low 20 cycles in run mode -> exactly one `press_pulse`, and `req_valid` high for one cycle at edge E8. Bounce low for 3 cycles then high -> no pulse.
- Config capture then write: mode 0, `switch_array`=12'h0A5, press; then `switch_array`=12'h03C, press; then mode 1, press with `req_ready`=1 -> `req_addr`=0x0A5, `req_wdata`=0x3C, `req_rw`=0, and `cfg_field` back at 0.
- Handshake stall: issue a request with `req_ready`=0 for 15 cycles, pressing again and changing `switch_array` meanwhile -> `req_*` stable and `req_valid` held. Raise `req_ready` -> `req_valid` clears the next edge, and no second request follows.
- Enable gating: `enable`=0, press in both modes -> no capture, no request, but `press_pulse` still fires. Set `enable`=1 and press -> request issued.
- Read request: capture data field with `switch_array`=12'h1FF -> `cfg_rw`=1 and `req_wdata`=0xFF after a run-mode press.
- Reset mid-request: assert `rst` asynchronously while `req_valid`=1 and `req_ready`=0 -> all outputs 0 immediately, without waiting for a clock edge. After release, a run-mode press issues `req_addr`=0.
